elevator_scan_ctrl: RTL
=======================

// Module: elevator_scan_ctrl
// PURPOSE
//  Parametrised N-floor elevator controller: successor to the fixed 4-floor FSM. Latches cabin and hall
//  requests into a pending set and serves them in SCAN order: keep direction while requests lie ahead, then reverse.
//  Timed MOVE and DOOR phases; door hold/reopen. Sits between board I/O decode (buttons/switches) and display/LED drivers.
// PARAMETERS
//  NUM_FLOORS   4    number of floors, >=2; floor 0 is the lowest
//  MOVE_CYCLES  50   clock cycles to travel one floor, >=2
//  DOOR_CYCLES  100  clock cycles door stays open without hold/reopen, >=2
//  FLOOR_W      $clog2(NUM_FLOORS)  width of floor index (derived, not overridden)
// PORTS
//  CLOCK_50   in   1           system clock
//  RESET_N    in   1           asynchronous, active-low reset
//  CAB_REQ    in   NUM_FLOORS  cabin buttons, active-high, bit i = floor i, any cycle high latches
//  HALL_REQ   in   NUM_FLOORS  hall call buttons, active-high, same encoding
//  DOOR_HOLD  in   1           while high in DOOR, door timer reloads (door stays open)
//  cur_floor  out  FLOOR_W     current floor index
//  dir_up     out  1           1 = up direction (last/current travel), 0 = down
//  moving     out  1           high in MOVE state
//  door_open  out  1           high in DOOR state
//  arrive     out  1           one-cycle pulse on the edge cur_floor changes
//  pending    out  NUM_FLOORS  outstanding request set (for LED display)
// BEHAVIOUR
//  Reset (async, RESET_N=0): state IDLE, cur_floor=0, dir_up=1, pending=0, all timers 0, moving/door_open/arrive=0.
//  Request latch: each edge, pending <= (pending | CAB_REQ | HALL_REQ) & ~clr; clr = bit of cur_floor when entering
//   DOOR or while in DOOR (request at open door never re-pends; it reloads the door timer instead).
//  States IDLE, MOVE, DOOR; decisions use registered pending only (1-cycle request-to-action latency).
//  IDLE: pending[cur]            -> DOOR, load door timer;
//        else pending ahead in dir_up -> MOVE same dir;
//        else pending behind          -> flip dir_up, MOVE;   else stay IDLE.
//   "ahead" = any pending bit above (dir_up=1) / below (dir_up=0) cur_floor.
//  MOVE: counter counts MOVE_CYCLES cycles; on last cycle cur_floor +/-1, arrive=1 for one cycle.
//        Then pending[new floor] -> DOOR; else pending still ahead -> stay MOVE (counter restarts); else -> IDLE.
//        Requests arriving mid-move for a floor ahead are served on the way (stop at that floor).
//  DOOR: counter counts DOOR_CYCLES cycles; DOOR_HOLD=1 or CAB/HALL request for cur_floor reloads to full.
//        On expiry -> IDLE (re-evaluates next cycle; dir_up kept).
//  Boundaries: never move below floor 0 or above NUM_FLOORS-1 (ahead-search excludes out-of-range);
//   at top floor dir_up forced 0 on next departure, at floor 0 forced 1.
//  Simultaneous requests above and below in IDLE: current dir_up wins (no starvation: reversal only when nothing ahead).
//  All-floors request: visits every floor once per sweep, one DOOR per floor.
//  Reset mid-MOVE/DOOR: immediate return to reset values; in-flight request lost.
//  Timing from request sampled at edge t, car idle at floor f, target g!=f: MOVE entered t+1,
//   cur_floor==g and door_open=1 at edge t+1+|g-f|*MOVE_CYCLES, door closes DOOR_CYCLES edges later.
// STRUCTURE
//  elevator_pkg: state enum (ST_IDLE/ST_MOVE/ST_DOOR), default timing constants, clog2 helper.
//  Sub-module elevator_dir_select: combinational, pending+cur_floor -> any_above, any_below, here.
//  Top holds FSM, shared down-counter (reloaded per phase), pending register.
// TESTING (bench with NUM_FLOORS=8, MOVE_CYCLES=4, DOOR_CYCLES=8)
//  1 Reset, CAB_REQ[3] pulse 1 cycle at t -> moving at t+1, arrive x3, cur_floor=3 & door_open at t+13, closed t+21.
//  2 At floor 3 idle, HALL_REQ[5] and HALL_REQ[1] same cycle, dir_up=1 -> serves 5 first, then reverses to 1.
//  3 Moving 0->6, HALL_REQ[4] raised while cur_floor=2 -> stops at 4 (door 8 cycles), continues to 6.
//  4 Door open at floor 2, DOOR_HOLD high 20 cycles then CAB_REQ[2] pulse -> door_open stays 1 until 8 cycles
//    after last reload; pending[2] never set.
//  5 All 8 HALL_REQ bits from floor 0 -> 7 arrive pulses, 8 door phases, floors 0..7 ascending, pending=0 at end.
//  6 RESET_N low mid-MOVE between floors 4-5 -> cur_floor=0, pending=0, moving=0 same cycle (async); idle after release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator controller.
// Holds the phase enum, default timing and a constant-evaluable log2 helper.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_e;

    localparam int DEF_NUM_FLOORS  = 4;
    localparam int DEF_MOVE_CYCLES = 50;
    localparam int DEF_DOOR_CYCLES = 100;

    // Smallest r with 2**r >= value; usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/elevator_dir_select.sv
// Combinational view of the pending set relative to one floor:
// anything above it, anything below it, and whether that floor itself is requested.
module elevator_dir_select #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = 2
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    floor,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  here
);

    // Reduce the pending set on each side of the floor of interest.
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            any_above = any_above | (pending[i] & (FLOOR_W'(i) > floor));
            any_below = any_below | (pending[i] & (FLOOR_W'(i) < floor));
        end
        here = pending[floor];
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor SCAN elevator controller: latches cabin/hall calls into a pending set and
// serves them by sweeping in one direction until nothing lies ahead, then reversing.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int  NUM_FLOORS  = DEF_NUM_FLOORS,
    parameter int  MOVE_CYCLES = DEF_MOVE_CYCLES,
    parameter int  DOOR_CYCLES = DEF_DOOR_CYCLES,
    localparam int FLOOR_W     = clog2(NUM_FLOORS)
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [NUM_FLOORS-1:0] CAB_REQ,
    input  logic [NUM_FLOORS-1:0] HALL_REQ,
    input  logic                  DOOR_HOLD,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrive,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int CNT_W = clog2((MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES);
    localparam logic [CNT_W-1:0]   MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [FLOOR_W-1:0] FLOOR_ONE = FLOOR_W'(1);

    state_e                  state_r, state_next_s;
    logic [CNT_W-1:0]        cnt_r, cnt_next_s;
    logic [FLOOR_W-1:0]      cur_floor_r, floor_next_s, step_floor_s, floor_sel_s;
    logic                    dir_up_r, dir_next_s;
    logic                    moving_r, door_open_r, arrive_r, arrive_next_s;
    logic [NUM_FLOORS-1:0]   pending_r, pending_next_s, clr_s, req_s;
    logic                    any_above_s, any_below_s, here_s, ahead_s, behind_s, req_here_s;

    assign req_s        = CAB_REQ | HALL_REQ;
    assign req_here_s   = req_s[cur_floor_r];
    assign step_floor_s = dir_up_r ? (cur_floor_r + FLOOR_ONE) : (cur_floor_r - FLOOR_ONE);
    // While moving, decisions are about the floor being reached, not the one being left.
    assign floor_sel_s  = (state_r == ST_MOVE) ? step_floor_s : cur_floor_r;
    assign ahead_s      = dir_up_r ? any_above_s : any_below_s;
    assign behind_s     = dir_up_r ? any_below_s : any_above_s;

    elevator_dir_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_dir_select (
        .pending   (pending_r),
        .floor     (floor_sel_s),
        .any_above (any_above_s),
        .any_below (any_below_s),
        .here      (here_s)
    );

    // Next-state, shared phase counter, floor and direction decisions.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        floor_next_s  = cur_floor_r;
        dir_next_s    = dir_up_r;
        arrive_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (here_s) begin
                    state_next_s = ST_DOOR;
                    cnt_next_s   = DOOR_LOAD;
                end else if (ahead_s) begin
                    state_next_s = ST_MOVE;
                    cnt_next_s   = MOVE_LOAD;
                end else if (behind_s) begin
                    state_next_s = ST_MOVE;
                    cnt_next_s   = MOVE_LOAD;
                    dir_next_s   = ~dir_up_r;
                end else begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end
            end
            ST_MOVE: begin
                if (cnt_r == CNT_ZERO) begin
                    floor_next_s  = step_floor_s;
                    arrive_next_s = 1'b1;
                    if (here_s) begin
                        state_next_s = ST_DOOR;
                        cnt_next_s   = DOOR_LOAD;
                    end else if (ahead_s) begin
                        state_next_s = ST_MOVE;
                        cnt_next_s   = MOVE_LOAD;
                    end else begin
                        state_next_s = ST_IDLE;
                        cnt_next_s   = CNT_ZERO;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            ST_DOOR: begin
                if (DOOR_HOLD || req_here_s) begin
                    cnt_next_s = DOOR_LOAD;
                end else if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // A call for the floor whose door is open (or opening) is absorbed, never pended.
    always_comb begin
        clr_s = {NUM_FLOORS{1'b0}};
        if ((state_r == ST_DOOR) || (state_next_s == ST_DOOR)) begin
            clr_s[floor_next_s] = 1'b1;
        end else begin
            clr_s = {NUM_FLOORS{1'b0}};
        end
        pending_next_s = (pending_r | req_s) & ~clr_s;
    end

    // State, counter, position and registered status outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            cur_floor_r <= {FLOOR_W{1'b0}};
            dir_up_r    <= 1'b1;
            pending_r   <= {NUM_FLOORS{1'b0}};
            moving_r    <= 1'b0;
            door_open_r <= 1'b0;
            arrive_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            cur_floor_r <= floor_next_s;
            dir_up_r    <= dir_next_s;
            pending_r   <= pending_next_s;
            moving_r    <= (state_next_s == ST_MOVE);
            door_open_r <= (state_next_s == ST_DOOR);
            arrive_r    <= arrive_next_s;
        end
    end

    assign cur_floor = cur_floor_r;
    assign dir_up    = dir_up_r;
    assign moving    = moving_r;
    assign door_open = door_open_r;
    assign arrive    = arrive_r;
    assign pending   = pending_r;

endmodule
